// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder: group width, the
// generate/propagate pair type and the 4-bit lookahead carry expansion.
package cla_pkg;

  localparam int unsigned GROUP_W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Flat sum-of-products carries for one 4-bit group; no c[i] -> c[i+1] chain.
  function automatic logic [4:1] lookahead_carries(input logic       cin,
                                                   input logic [3:0] g,
                                                   input logic [3:0] p);
    logic [4:1] c;
    c[1] = g[0]
         | (p[0] & cin);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

endpackage

// File: rtl/cla_adder_cla4_block.sv
// One 4-bit lookahead group: sum slice from the group carry-in, plus the
// group generate/propagate pair consumed by the second lookahead level.
module cla4_block
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum_c,
  output gp_t        grp_c
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] c;
  logic       unused_cout;

  always_comb begin
    g      = a & b;
    p      = a ^ b;
    c      = lookahead_carries(cin, g, p);
    sum_c  = p ^ {c[3:1], cin};
    grp_c.g = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
    grp_c.p = &p;
  end

  // Group carry-out comes from the top-level lookahead, not from here.
  assign unused_cout = c[4];

endmodule

// File: rtl/cla_adder.sv
// Registered unsigned carry-lookahead adder; sum[WIDTH] is the carry-out.
// WIDTH/4 lookahead groups joined by a second-level lookahead over GG/GP.
module cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  localparam int unsigned NGRP = WIDTH / GROUP_W;

  if ((WIDTH == 0) || ((WIDTH % GROUP_W) != 0)) begin : g_bad_width
    $error("cla_adder: WIDTH must be a positive multiple of 4");
  end

  gp_t              grp_w [NGRP];
  logic [NGRP:0]    grp_cin;
  logic [WIDTH-1:0] slice_sum;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   sum_q;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    cla4_block u_blk (
      .a     (a[k*GROUP_W +: GROUP_W]),
      .b     (b[k*GROUP_W +: GROUP_W]),
      .cin   (grp_cin[k]),
      .sum_c (slice_sum[k*GROUP_W +: GROUP_W]),
      .grp_c (grp_w[k])
    );
  end

  // Second-level lookahead: carry into group k is an OR over j<k of
  // GG[j] & GP[j+1..k-1]; adder carry-in is zero so no cin term.
  always_comb begin : p_grp_carry
    logic term;
    grp_cin = '0;
    term    = 1'b0;
    for (int k = 1; k <= int'(NGRP); k++) begin
      for (int j = 0; j < k; j++) begin
        term = grp_w[j].g;
        for (int m = j + 1; m < k; m++) begin
          term = term & grp_w[m].p;
        end
        grp_cin[k] = grp_cin[k] | term;
      end
    end
  end

  always_comb begin
    sum_d = {grp_cin[NGRP], slice_sum};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder at WIDTH=4, 8 and 16 against a plain
// a+b reference, one cycle delayed, with reset forcing zero.
module tb_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a4,  b4;
  logic [7:0]  a8,  b8;
  logic [15:0] a16, b16;
  logic [4:0]  sum4;
  logic [8:0]  sum8;
  logic [16:0] sum16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_adder #(.WIDTH(4)) u_dut4 (
    .clk (clk), .rst (rst), .a (a4), .b (b4), .sum (sum4)
  );
  cla_adder #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst (rst), .a (a8), .b (b8), .sum (sum8)
  );
  cla_adder #(.WIDTH(16)) u_dut16 (
    .clk (clk), .rst (rst), .a (a16), .b (b16), .sum (sum16)
  );

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive all three adders for one cycle and check the registered result.
  task automatic cycle(input logic r, input logic [3:0] x4, input logic [3:0] y4,
                       input logic [7:0] x8, input logic [7:0] y8,
                       input logic [15:0] x16, input logic [15:0] y16,
                       input string tag);
    int unsigned e4, e8, e16;
    rst = r; a4 = x4; b4 = y4; a8 = x8; b8 = y8; a16 = x16; b16 = y16;
    e4  = r ? 0 : int'(x4)  + int'(y4);
    e8  = r ? 0 : int'(x8)  + int'(y8);
    e16 = r ? 0 : int'(x16) + int'(y16);
    @(posedge clk);
    #1;
    check({tag, "_w4"},  17'(sum4),  17'(e4));
    check({tag, "_w8"},  17'(sum8),  17'(e8));
    check({tag, "_w16"}, 17'(sum16), 17'(e16));
  endtask

  task automatic pair4(input logic r, input int x, input int y, input string tag);
    cycle(r, 4'(x), 4'(y), 8'(x), 8'(y), 16'(x), 16'(y), tag);
  endtask

  initial begin
    rst = 1'b1;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    @(negedge clk);

    // reset holds output at zero even with saturating operands
    cycle(1'b1, 4'hF, 4'hF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, "rst0");
    cycle(1'b1, 4'hF, 4'hF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, "rst1");
    cycle(1'b0, 4'hF, 4'hF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, "max");

    pair4(1'b0, 2, 7, "nc_2p7");
    pair4(1'b0, 1, 6, "nc_1p6");
    pair4(1'b0, 5, 3, "nc_5p3");
    pair4(1'b0, 5, 5, "nc_5p5");

    pair4(1'b0, 4, 12, "co_4p12");
    pair4(1'b0, 13, 10, "co_13p10");
    pair4(1'b0, 9, 8, "co_9p8");
    pair4(1'b0, 15, 1, "co_15p1");

    pair4(1'b0, 13, 10, "mr_13p10");
    pair4(1'b1, 9, 8, "mr_rst");
    pair4(1'b0, 2, 7, "mr_2p7");

    // exhaustive 4-bit, wider adders on random data alongside
    for (int i = 0; i < 256; i++) begin
      cycle(1'b0, 4'(i >> 4), 4'(i), 8'($urandom), 8'($urandom),
            16'($urandom), 16'($urandom), "exh");
    end

    cycle(1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 16'h0000, 16'h0000, "zero");
    cycle(1'b0, 4'hF, 4'hF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, "ones");
    cycle(1'b0, 4'h8, 4'h8, 8'h80, 8'h80, 16'h8000, 16'h8000, "msb");
    cycle(1'b0, 4'hF, 4'h1, 8'hFF, 8'h01, 16'hFFFF, 16'h0001, "prop");

    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 199) == 0), 4'($urandom), 4'($urandom),
            8'($urandom), 8'($urandom), 16'($urandom), 16'($urandom), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_adder.md
Name: cla_adder

Overview:
- Registered unsigned carry-lookahead adder: sum = a + b, carry-out kept as the MSB of sum.
- Default configuration is 4-bit operands with a 5-bit result.
- Datapath arithmetic primitive, usable standalone or as the adder stage in larger datapaths.
- Carry generation is true lookahead (generate/propagate), not ripple, so the adder scales to wider operands by grouping 4-bit lookahead blocks.

Parameters:
- WIDTH, 4, operand width in bits; must be a positive multiple of 4 (elaboration-time assertion otherwise).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- a    input  WIDTH  operand A, unsigned
- b    input  WIDTH  operand B, unsigned
- sum  output WIDTH+1  registered a+b; bit WIDTH is carry-out

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset: on a rising clk edge with rst=1, sum <= 0. rst overrides any operand value in that cycle.
- Latency: exactly 1 cycle.
  - a/b sampled at rising edge N (rst=0) appear on sum after edge N.
  - Full throughput: a new operand pair every cycle, no handshake, no stall.
- Arithmetic: unsigned, no carry-in (c0 = 0).
  - sum = zero-extended a + zero-extended b, computed modulo 2^(WIDTH+1). It never overflows.
  - Maximum result is 2^(WIDTH+1) - 2; for WIDTH=4 that is 15+15 = 30.
- Carry logic, per bit i:
  - g[i] = a[i] & b[i]
  - p[i] = a[i] ^ b[i]
  - s[i] = p[i] ^ c[i]
- Within each 4-bit group, carries c1..c4 are expanded sum-of-products of g/p and the group carry-in, with no chaining of c[i] -> c[i+1].
- Each group also produces a group generate GG and a group propagate GP.
- Across groups, carries are computed by a second lookahead level over GG/GP. For WIDTH=4 there is a single group with carry-in 0.
- Carry-out of the top group is sum[WIDTH].
- Combinational sum/carry logic is purely a function of the current a and b. Only the output register holds state.
- Reset asserted mid-stream:
  - Any in-flight result is discarded and sum reads 0 after the reset edge.
  - The first result after deassertion corresponds to operands sampled on the first edge with rst=0.
- X/Z on inputs is not required to be handled; inputs must be driven when rst=0.

Decomposition:
- Package cla_pkg:
  - localparam GROUP_W = 4
  - typedef struct {g, p} for a group generate/propagate pair
  - helper function for group lookahead carries (cin, g[3:0], p[3:0]) -> c[4:1]
- Sub-module cla4_block:
  - Inputs: 4-bit a, 4-bit b, cin.
  - Outputs: 4-bit sum slice, GG, GP.
  - Instantiated WIDTH/4 times via generate.
- The top level holds:
  - the inter-group lookahead carry unit (generate loop or function)
  - the WIDTH+1-bit output register with synchronous reset

Test Plan:
- Reset: hold rst=1 with a=4'd15, b=4'd15 for 2 cycles -> sum=5'd0; release rst -> sum=5'd30 one cycle later.
- No-carry sums, one pair per cycle:
  - 2+7 -> 9
  - 1+6 -> 7
  - 5+3 -> 8
  - 5+5 -> 10
  - Each result must appear exactly one cycle after its operands, back-to-back.
- Carry-out cases:
  - 4+12 -> 16 (sum[4]=1, low nibble 0)
  - 13+10 -> 23
  - 9+8 -> 17
  - 15+1 -> 16 (full propagate chain)
- Mid-stream reset: stream 13+10 then 9+8, assert rst in the 9+8 cycle -> sum=0 instead of 17; next operand pair 2+7 after deassert -> 9.
- Exhaustive/random:
  - All 256 (a,b) pairs for WIDTH=4, compared against a+b one cycle delayed.
  - Repeat with WIDTH=8 and WIDTH=16, 10k random vectors each, including 0+0 -> 0 and all-ones+all-ones -> 2^(WIDTH+1)-2.
